slink_prbs_seq: RTL and testbench

- Training-pattern sequencer for link bring-up.
- Owns two 9-bit PRBS9 states: a TX generator that emits PRBS bytes over a valid/ready handshake, and an RX checker that compares received bytes in lockstep.
- Runs a software-configured burst of N bytes, counts mismatches and reports done/pass.
- Sits between the link-training FSM/CSRs and the lane byte datapath.

---
 rtl/slink_prbs_pkg.sv | 29 ++
 rtl/slink_prbs_chk.sv | 54 +++++
 rtl/slink_prbs_seq.sv | 126 ++++++++++++
 tb/tb_slink_prbs_seq.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slink_prbs_pkg.sv
// Shared types and the byte-wide PRBS9 (x^9+x^5+1) advance used by the
// slink_prbs_seq training-pattern sequencer and its RX checker.
package slink_prbs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Substitute for an all-zero seed, which would lock the LFSR.
  localparam logic [8:0] PRBS9_ZERO_SUB = 9'h1FF;

  // Eight serial steps of x^9+x^5+1 collapsed into one byte advance.
  function automatic logic [8:0] prbs9_step(input logic [8:0] p);
    logic [8:0] n;
    n[8] = p[0];
    n[7] = p[8] ^ p[4];
    n[6] = p[7] ^ p[3];
    n[5] = p[6] ^ p[2];
    n[4] = p[5] ^ p[1];
    n[3] = p[4] ^ p[0];
    n[2] = p[3] ^ p[8] ^ p[4];
    n[1] = p[2] ^ p[7] ^ p[3];
    n[0] = p[1] ^ p[6] ^ p[2];
    return n;
  endfunction

endpackage

// File: rtl/slink_prbs_chk.sv
// RX side of slink_prbs_seq: lockstep PRBS9 reference, received-byte count
// and a saturating mismatch counter.
module slink_prbs_chk
  import slink_prbs_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [8:0]       i_seed,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_run,
  input  logic             i_rx_valid,
  input  logic [7:0]       i_rx_data,
  output logic             o_rx_done,
  output logic [ERR_W-1:0] o_err_cnt
);

  logic [8:0]       r_rx_lfsr;
  logic [LEN_W-1:0] r_rx_cnt;
  logic [ERR_W-1:0] r_err_cnt;
  logic             w_take;
  logic             w_mismatch;
  logic             w_err_sat;

  // Bytes beyond the configured length are not part of the burst.
  assign w_take     = i_run & i_rx_valid & (r_rx_cnt < i_len);
  assign w_mismatch = (i_rx_data != r_rx_lfsr[7:0]);
  assign w_err_sat  = (r_err_cnt == {ERR_W{1'b1}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_lfsr <= 9'h000;
      r_rx_cnt  <= '0;
      r_err_cnt <= '0;
    end else if (i_load) begin
      r_rx_lfsr <= i_seed;
      r_rx_cnt  <= '0;
      r_err_cnt <= '0;
    end else if (w_take) begin
      r_rx_lfsr <= prbs9_step(r_rx_lfsr);
      r_rx_cnt  <= r_rx_cnt + 1'b1;
      if (w_mismatch && !w_err_sat) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign o_rx_done = (r_rx_cnt == i_len);
  assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/slink_prbs_seq.sv
// PRBS9 training-pattern sequencer: TX generator over valid/ready plus RX
// checker. Optional one-shot TX bit-0 corruption under SLINK_PRBS_ERR_INJECT_EN.
module slink_prbs_seq
  import slink_prbs_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
`ifdef SLINK_PRBS_ERR_INJECT_EN
  input  logic             inject,
`endif
  input  logic [8:0]       cfg_seed,
  input  logic [LEN_W-1:0] cfg_len,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       dbg_state
);

  // Handshake: a TX byte transfers on a clock edge where tx_valid & tx_ready;
  // while tx_valid is high and tx_ready low, tx_data holds. RX has no
  // backpressure: every rx_valid cycle delivers one byte.

  state_t           r_state;
  state_t           w_next_state;
  logic [8:0]       r_tx_lfsr;
  logic [LEN_W-1:0] r_tx_cnt;
  logic [LEN_W-1:0] r_len;
  logic             w_start_ok;
  logic             w_tx_hs;
  logic             w_tx_done;
  logic             w_rx_done;
  logic [8:0]       w_seed;
  logic             w_inj_bit;

  assign w_seed     = (cfg_seed == 9'h000) ? PRBS9_ZERO_SUB : cfg_seed;
  assign w_start_ok = start & ~abort & ((r_state == IDLE) | (r_state == DONE));
  assign w_tx_hs    = tx_valid & tx_ready;
  assign w_tx_done  = (r_tx_cnt == r_len);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: if (start) w_next_state = (cfg_len == '0) ? DONE : RUN;
        RUN:        if (w_tx_done && w_rx_done) w_next_state = DONE;
        default:    w_next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    tx_valid  = (r_state == RUN) & (r_tx_cnt < r_len);
    tx_data   = r_tx_lfsr[7:0] ^ {7'b0, w_inj_bit};
    busy      = (r_state == RUN);
    done      = (r_state == DONE);
    pass      = done & (err_cnt == '0);
    dbg_state = r_state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_lfsr <= 9'h000;
      r_tx_cnt  <= '0;
      r_len     <= '0;
    end else if (w_start_ok) begin
      r_tx_lfsr <= w_seed;
      r_tx_cnt  <= '0;
      r_len     <= cfg_len;
    end else if (w_tx_hs) begin
      r_tx_lfsr <= prbs9_step(r_tx_lfsr);
      r_tx_cnt  <= r_tx_cnt + 1'b1;
    end
  end

`ifdef SLINK_PRBS_ERR_INJECT_EN
  logic r_inj_arm;

  // A fresh pulse re-arms for the following byte even if it coincides with
  // the handshake that consumes the current arm.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_inj_arm <= 1'b0;
    else if (abort)   r_inj_arm <= 1'b0;
    else if (inject)  r_inj_arm <= 1'b1;
    else if (w_tx_hs) r_inj_arm <= 1'b0;
  end

  assign w_inj_bit = r_inj_arm;
`else
  assign w_inj_bit = 1'b0;
`endif

  slink_prbs_chk #(
    .LEN_W (LEN_W),
    .ERR_W (ERR_W)
  ) u_chk (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_start_ok),
    .i_seed     (w_seed),
    .i_len      (r_len),
    .i_run      (r_state == RUN),
    .i_rx_valid (rx_valid),
    .i_rx_data  (rx_data),
    .o_rx_done  (w_rx_done),
    .o_err_cnt  (err_cnt)
  );

endmodule

// File: tb/tb_slink_prbs_seq.sv
// Bench for slink_prbs_seq: loopback bursts checked against a serial-LFSR
// PRBS9 model; a second instance with ERR_W=2 covers counter saturation.
module tb_slink_prbs_seq;

  localparam int LEN_W = 16;
  localparam int ERR_W = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [8:0]       cfg_seed = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             tx_ready = 1'b0;
  logic [7:0]       rx_data = '0;
  logic             rx_valid = 1'b0;
`ifdef SLINK_PRBS_ERR_INJECT_EN
  logic             inject = 1'b0;
`endif

  logic [7:0]       tx_data, tx_data_s;
  logic             tx_valid, tx_valid_s;
  logic             busy, busy_s, done, done_s, pass, pass_s;
  logic [ERR_W-1:0] err_cnt;
  logic [1:0]       err_cnt_s;
  logic [1:0]       dbg_state, dbg_state_s;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // clock / reset
  always #5 clk = ~clk;

  slink_prbs_seq #(.LEN_W(LEN_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
`ifdef SLINK_PRBS_ERR_INJECT_EN
    .inject(inject),
`endif
    .cfg_seed(cfg_seed), .cfg_len(cfg_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  slink_prbs_seq #(.LEN_W(LEN_W), .ERR_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
`ifdef SLINK_PRBS_ERR_INJECT_EN
    .inject(inject),
`endif
    .cfg_seed(cfg_seed), .cfg_len(cfg_len),
    .tx_data(tx_data_s), .tx_valid(tx_valid_s), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_cnt_s), .dbg_state(dbg_state_s)
  );

  // Reference: PRBS9 as a plain left-shifting Fibonacci register, 8 shifts per byte.
  task automatic model_bytes(input logic [8:0] seed, input int len);
    logic [8:0] s;
    s = (seed == 9'h000) ? 9'h1FF : seed;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(s[7:0]);
      for (int b = 0; b < 8; b++) s = {s[7:0], s[8] ^ s[4]};
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic start_burst(input logic [8:0] seed, input int len);
    @(posedge clk); #1;
    cfg_seed = seed; cfg_len = LEN_W'(len); start = 1'b1;
`ifdef SLINK_PRBS_ERR_INJECT_EN
    inject = 1'b0;
`endif
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // rmode: 0 always ready, 1 pattern 1,0,0,..., 2 random
  // cmode: 0 clean, 1 flip bit3 of bytes 1 and 2, 2 random flips, 3 flip all
  task automatic run_burst(input logic [8:0] seed, input int len, input int rmode,
                           input int cmode, input bit inj);
    bit corrupt[$];
    int exp_err, exp_sat, hs, cyc;
    bit prev_stall, have_rx, nxt_rx;
    logic [7:0] prev_data, rx_byte, nxt_byte, exp_b;
    model_bytes(seed, len);
    if (inj && len > 0) exp_q[0] = exp_q[0] ^ 8'h01;
    exp_err = 0;
    for (int i = 0; i < len; i++) begin
      case (cmode)
        1: corrupt.push_back(i == 1 || i == 2);
        2: corrupt.push_back($urandom_range(0, 3) == 0);
        3: corrupt.push_back(1'b1);
        default: corrupt.push_back(1'b0);
      endcase
      if (corrupt[i] || (inj && i == 0)) exp_err++;
    end
    exp_sat = (exp_err > 3) ? 3 : exp_err;
    got_q.delete();
`ifdef SLINK_PRBS_ERR_INJECT_EN
    if (inj) begin
      @(posedge clk); #1 inject = 1'b1;
    end
`endif
    start_burst(seed, len);
    checks++;
    if (tx_valid !== (len > 0) || busy !== (len > 0) || done !== (len == 0)) begin
      errors++;
      $display("FAIL start_latency: valid=%b busy=%b done=%b len=%0d", tx_valid, busy, done, len);
    end
    hs = 0; cyc = 0; prev_stall = 0; have_rx = 0; rx_byte = '0; prev_data = '0;
    while (!done && cyc < 2000) begin
      rx_valid = have_rx;
      rx_data  = have_rx ? rx_byte : 8'($urandom);
      case (rmode)
        1: tx_ready = (cyc % 3 == 0);
        2: tx_ready = ($urandom_range(0, 1) == 1);
        default: tx_ready = 1'b1;
      endcase
      nxt_rx = 0; nxt_byte = '0;
      if (tx_valid) begin
        if (prev_stall) begin
          checks++;
          if (tx_data !== prev_data) begin
            errors++;
            $display("FAIL stall_hold: got %02h required %02h", tx_data, prev_data);
          end
        end
        if (tx_ready) begin
          exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          checks++;
          if (tx_data !== exp_b) begin
            errors++;
            $display("FAIL tx_byte[%0d]: got %02h required %02h", hs, tx_data, exp_b);
          end
          got_q.push_back(tx_data);
          nxt_rx = 1;
          nxt_byte = tx_data ^ ((hs < len && corrupt[hs]) ? 8'h08 : 8'h00);
          hs++;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
        end
        prev_data = tx_data;
      end
      @(posedge clk); #1;
      cyc++;
      have_rx = nxt_rx; rx_byte = nxt_byte;
    end
    rx_valid = 1'b0; tx_ready = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: done=%b after %0d cycles", done, cyc);
    end
    checks++;
    if (hs != len) begin
      errors++;
      $display("FAIL handshake_count: got %0d required %0d", hs, len);
    end
    checks++;
    if (err_cnt !== ERR_W'(exp_err) || pass !== (exp_err == 0) || busy !== 1'b0) begin
      errors++;
      $display("FAIL burst_result: err=%0d pass=%b busy=%b required err=%0d pass=%b",
               err_cnt, pass, busy, exp_err, exp_err == 0);
    end
    checks++;
    if (err_cnt_s !== 2'(exp_sat) || done_s !== 1'b1) begin
      errors++;
      $display("FAIL err_saturate: got %0d done=%b required %0d", err_cnt_s, done_s, exp_sat);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0 ||
        pass !== 1'b0 || err_cnt !== '0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%02h busy=%b done=%b pass=%b err=%0d st=%0d",
               tx_valid, tx_data, busy, done, pass, err_cnt, dbg_state);
    end
  endtask

  task automatic test_basic();
    logic [7:0] ref_b [3];
    ref_b[0] = 8'hFF; ref_b[1] = 8'h07; ref_b[2] = 8'hBE;
    run_burst(9'h1FF, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_q.size() <= i || got_q[i] !== ref_b[i]) begin
        errors++;
        $display("FAIL basic_vector[%0d]: got %02h required %02h", i,
                 (got_q.size() > i) ? got_q[i] : 8'hxx, ref_b[i]);
      end
    end
  endtask

  task automatic test_zero_seed();
    run_burst(9'h000, 2, 0, 0, 0);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 8'hFF || got_q[1] !== 8'h07) begin
      errors++;
      $display("FAIL zero_seed: got %0d bytes first %02h required FF 07",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
  endtask

  task automatic test_stall();
    run_burst(9'(($urandom_range(1, 511))), 4, 1, 0, 0);
    run_burst(9'h0A5, 9, 2, 0, 0);
  endtask

  task automatic test_errors();
    run_burst(9'h1FF, 4, 0, 1, 0);
    run_burst(9'h123, 5, 0, 3, 0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 6; n++) begin
      run_burst(9'($urandom_range(0, 511)), $urandom_range(1, 20),
                $urandom_range(0, 2), $urandom_range(0, 2), 0);
    end
  endtask

  task automatic test_abort();
    start = 1'b1; abort = 1'b1; cfg_len = 16'd4;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checks++;
    if (dbg_state !== 2'd0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_beats_start: state=%0d valid=%b required 0 0", dbg_state, tx_valid);
    end
    model_bytes(9'h1FF, 4);
    start_burst(9'h1FF, 4);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0; rx_valid = 1'b1; rx_data = exp_q[0] ^ 8'h40;
    @(posedge clk); #1;
    rx_valid = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL abort_idle: valid=%b busy=%b done=%b state=%0d", tx_valid, busy, done, dbg_state);
    end
    checks++;
    if (err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL abort_err_held: got %0d required 1", err_cnt);
    end
    start_burst(9'h055, 0);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || err_cnt !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len_zero: done=%b pass=%b err=%0d busy=%b required 1 1 0 0",
               done, pass, err_cnt, busy);
    end
  endtask

  task automatic test_async_reset();
    start_burst(9'h0F0, 10);
    tx_ready = 1'b1;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || err_cnt !== '0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%02h busy=%b err=%0d state=%0d",
               tx_valid, tx_data, busy, err_cnt, dbg_state);
    end
    tx_ready = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

`ifdef SLINK_PRBS_ERR_INJECT_EN
  task automatic test_inject();
    run_burst(9'h1FF, 3, 0, 0, 1);
    checks++;
    if (got_q.size() != 3 || got_q[0] !== 8'hFE || got_q[1] !== 8'h07 || got_q[2] !== 8'hBE) begin
      errors++;
      $display("FAIL inject_bytes: got %0d bytes first %02h required FE 07 BE",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_seed();
    test_stall();
    test_errors();
    test_back_to_back();
    test_abort();
    test_async_reset();
`ifdef SLINK_PRBS_ERR_INJECT_EN
    test_inject();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
